// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
//   state_t     : debounce FSM states
//   frame_cls_t : classification of one complete scan frame
//   classify()  : reduces a 16-bit pressed map to NONE / SINGLE(key) / MULTI
package keypad_pkg;
  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEYS  = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_cls_t;

  typedef struct packed {
    frame_cls_t       cls;
    logic [KEY_W-1:0] key;   // only meaningful when cls == FR_SINGLE
  } frame_res_t;

  // Frame bit index doubles as the key code (row*COLS + col).
  function automatic frame_res_t classify(input logic [KEYS-1:0] f);
    frame_res_t  res;
    int unsigned n;
    res.cls = FR_NONE;
    res.key = '0;
    n       = 0;
    for (int i = 0; i < KEYS; i++) begin
      if (f[i]) begin
        n       = n + 1;
        res.key = KEY_W'(i);
      end
    end
    if (n == 1)     res.cls = FR_SINGLE;
    else if (n > 1) res.cls = FR_MULTI;
    return res;
  endfunction
endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk, reset_n : clock, async active-low reset (flops reset to all ones,
//                  matching idle pulled-up inputs)
//   d            : asynchronous input, WIDTH bits
//   q            : synchronised output, WIDTH bits
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-frame debounce.
//   clk, reset_n : clock, async active-low reset
//   row_n        : keypad rows, active-low, asynchronous
//   col_n        : column drive, active-low, one bit low at a time
//   key_code     : last accepted key (row*4 + col)
//   key_valid    : one-cycle strobe on a newly accepted press
//   key_held     : high while the accepted key is considered pressed
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS);

  logic [ROWS-1:0]  row_s;
  logic [DW-1:0]    div;
  logic [1:0]       col;
  logic [KEYS-1:0]  frame, frame_now;
  logic [CW-1:0]    cnt, cnt_inc;
  logic [KEY_W-1:0] cand;
  state_t           state;
  frame_res_t       res;
  logic             sample, match_cand, match_code;

  sync2 #(.WIDTH(ROWS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (row_n),
    .q       (row_s)
  );

  assign sample  = (div == DIV_LAST);
  assign cnt_inc = cnt + 1'b1;

  // The stored frame holds columns 0..2; on column 3's sample cycle the
  // current row sample is merged in so the full frame is classified without
  // waiting an extra cycle.
  always_comb begin
    frame_now = frame;
    for (int r = 0; r < ROWS; r++) frame_now[r*COLS + int'(col)] = ~row_s[r];
    res = classify(frame_now);
  end

  assign match_cand = (res.cls == FR_SINGLE) && (res.key == cand);
  assign match_code = (res.cls == FR_SINGLE) && (res.key == key_code);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div       <= '0;
      col       <= '0;
      col_n     <= 4'b1110;
      frame     <= '0;
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (!sample) begin
        div <= div + 1'b1;
      end else begin
        div   <= '0;
        col   <= col + 1'b1;
        col_n <= ~(COLS'(1) << (col + 2'd1));
        frame <= frame_now;
        if (col == 2'd3) begin
          case (state)
            IDLE: begin
              if (res.cls == FR_SINGLE) begin
                state <= DEBOUNCE;
                cand  <= res.key;
                cnt   <= CW'(1);
              end
            end
            DEBOUNCE: begin
              if (match_cand) begin
                if (cnt_inc == CNT_LAST) begin
                  state     <= PRESSED;
                  key_code  <= cand;
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                end else begin
                  cnt <= cnt_inc;
                end
              end else if (res.cls == FR_SINGLE) begin
                cand <= res.key;
                cnt  <= CW'(1);
              end else begin
                state <= IDLE;
              end
            end
            PRESSED: begin
              if (!match_code) begin
                state <= RELEASE;
                cnt   <= CW'(1);
              end
            end
            RELEASE: begin
              // A returning key resumes PRESSED silently: no second strobe.
              if (match_code) begin
                state <= PRESSED;
              end else if (cnt_inc == CNT_LAST) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else begin
                cnt <= cnt_inc;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3,
// 16-cycle frames). Key sets change only at frame boundaries; a frame-level
// reference model predicts strobes, key_held and key_code per frame.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_n, col_n, key_code;
  logic       key_valid, key_held;
  logic [15:0] pressed = '0;
  logic [3:0] col_seen [FRAME];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         pulses;
    int         pulse_at;
    logic       held_mid;
    logic       held_end;
    logic [3:0] code_end;
  } obs_t;

  // Reference model state (frame level)
  bit m_held;
  int m_code, m_run_key, m_run_len, m_miss;

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its driven-low column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
  end

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic model_reset();
    m_held = 0; m_code = 0; m_run_key = 0; m_run_len = 0; m_miss = 0;
  endtask

  // Applies one frame's key set; returns 1 when a press is accepted.
  function automatic bit model_frame(input logic [15:0] p);
    int n = $countones(p);
    int k = -1;
    bit acc = 0;
    for (int i = 0; i < 16; i++) if (p[i]) k = i;
    if (!m_held) begin
      if (n == 1) begin
        m_run_len = (k == m_run_key) ? m_run_len + 1 : 1;
        m_run_key = k;
        if (m_run_len == DB) begin
          m_held = 1; m_code = k; m_miss = 0; acc = 1;
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (n == 1 && k == m_code) m_miss = 0;
      else begin
        m_miss = m_miss + 1;
        if (m_miss == DB) begin m_held = 0; m_run_len = 0; end
      end
    end
    return acc;
  endfunction

  // Drives one full frame starting just after a frame boundary and records
  // what the DUT showed during it.
  task automatic run_frame(input logic [15:0] p, output obs_t o);
    pressed    = p;
    o.pulses   = 0;
    o.pulse_at = -1;
    o.held_mid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      @(negedge clk);
      col_seen[i] = col_n;
      if (key_valid === 1'b1) begin o.pulses = o.pulses + 1; o.pulse_at = i; end
      if (i == FRAME/2) o.held_mid = key_held;
    end
    o.held_end = key_held;
    o.code_end = key_code;
  endtask

  task automatic test_reset();
    obs_t o;
    int bad;
    reset_n = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (col_n !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: col_n=%b code=%0d valid=%b held=%b want 1110/0/0/0",
               col_n, key_code, key_valid, key_held);
    end
    reset_n = 1'b1;
    model_reset();
    for (int f = 0; f < 10; f++) begin
      run_frame('0, o);
      void'(model_frame('0));
      bad = 0;
      for (int i = 0; i < FRAME; i++)
        if (col_seen[i] !== ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4))) bad++;
      checks++;
      if (bad != 0 || o.pulses != 0 || o.held_end !== 1'b0 || o.code_end !== 4'd0) begin
        failures++;
        $display("FAIL idle_scan f%0d: col_errs=%0d pulses=%0d held=%b code=%0d want 0/0/0/0",
                 f, bad, o.pulses, o.held_end, o.code_end);
      end
    end
  endtask

  task automatic test_single_key();
    logic [15:0] seq [9];
    obs_t o;
    bit acc, prev_held;
    int total = 0, acc_frame = -1;
    for (int f = 0; f < 9; f++) seq[f] = (f < 6) ? 16'h0200 : 16'h0000;
    for (int f = 0; f < 9; f++) begin
      run_frame(seq[f], o);
      prev_held = m_held;
      acc = model_frame(seq[f]);
      total += o.pulses;
      if (o.pulses != 0) acc_frame = f;
      checks++;
      if (o.pulses != (acc ? 1 : 0) || (acc && o.pulse_at != FRAME - 1)) begin
        failures++;
        $display("FAIL key9_pulse f%0d: pulses=%0d at=%0d want %0d at %0d",
                 f, o.pulses, o.pulse_at, acc ? 1 : 0, FRAME - 1);
      end
      checks++;
      if (o.held_mid !== prev_held || o.held_end !== m_held || o.code_end !== 4'(m_code)) begin
        failures++;
        $display("FAIL key9_state f%0d: held=%b/%b code=%0d want %b/%b code=%0d",
                 f, o.held_mid, o.held_end, o.code_end, prev_held, m_held, m_code);
      end
    end
    checks++;
    if (total != 1 || acc_frame != 2 || key_code !== 4'd9 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL key9_summary: pulses=%0d frame=%0d code=%0d held=%b want 1/2/9/0",
               total, acc_frame, key_code, key_held);
    end
  endtask

  task automatic test_bounce();
    obs_t o;
    bit acc;
    int total = 0, held_seen = 0;
    for (int f = 0; f < 8; f++) begin
      logic [15:0] p = (f % 2 == 0) ? 16'h0020 : 16'h0000;
      run_frame(p, o);
      acc = model_frame(p);
      total += o.pulses;
      if (o.held_mid !== 1'b0 || o.held_end !== 1'b0) held_seen++;
      checks++;
      if (o.pulses != (acc ? 1 : 0) || o.held_end !== m_held) begin
        failures++;
        $display("FAIL bounce f%0d: pulses=%0d held=%b want %0d/%b",
                 f, o.pulses, o.held_end, acc ? 1 : 0, m_held);
      end
    end
    checks++;
    if (total != 0 || held_seen != 0) begin
      failures++;
      $display("FAIL bounce_summary: pulses=%0d held_frames=%0d want 0/0", total, held_seen);
    end
  endtask

  task automatic test_multi();
    obs_t o;
    bit acc;
    int total_multi = 0;
    for (int f = 0; f < 11; f++) begin
      logic [15:0] p = (f < 5) ? 16'h8001 : (f < 8) ? 16'h8000 : 16'h0000;
      run_frame(p, o);
      acc = model_frame(p);
      if (f < 5) total_multi += o.pulses;
      checks++;
      if (o.pulses != (acc ? 1 : 0) || o.held_end !== m_held || o.code_end !== 4'(m_code)) begin
        failures++;
        $display("FAIL multi f%0d: pulses=%0d held=%b code=%0d want %0d/%b/%0d",
                 f, o.pulses, o.held_end, o.code_end, acc ? 1 : 0, m_held, m_code);
      end
      if (f == 7) begin
        checks++;
        if (o.pulses != 1 || o.code_end !== 4'd15) begin
          failures++;
          $display("FAIL key15_accept: pulses=%0d code=%0d want 1/15", o.pulses, o.code_end);
        end
      end
    end
    checks++;
    if (total_multi != 0) begin
      failures++;
      $display("FAIL multi_reject: pulses=%0d want 0", total_multi);
    end
  endtask

  task automatic test_glitch();
    obs_t o;
    bit acc, prev_held;
    int total = 0, held_drop = 0;
    for (int f = 0; f < 10; f++) begin
      logic [15:0] p = (f == 3 || f >= 7) ? 16'h0000 : 16'h0008;
      run_frame(p, o);
      prev_held = m_held;
      acc = model_frame(p);
      total += o.pulses;
      if (f >= 3 && f <= 6 && (o.held_mid !== 1'b1 || o.held_end !== 1'b1)) held_drop++;
      checks++;
      if (o.pulses != (acc ? 1 : 0) || o.held_mid !== prev_held || o.held_end !== m_held) begin
        failures++;
        $display("FAIL glitch f%0d: pulses=%0d held=%b/%b want %0d %b/%b",
                 f, o.pulses, o.held_mid, o.held_end, acc ? 1 : 0, prev_held, m_held);
      end
    end
    checks++;
    if (total != 1 || held_drop != 0 || key_code !== 4'd3) begin
      failures++;
      $display("FAIL glitch_summary: pulses=%0d drops=%0d code=%0d want 1/0/3",
               total, held_drop, key_code);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit acc;
    int early = 0;
    run_frame(16'h0080, o);
    void'(model_frame(16'h0080));
    for (int i = 0; i < FRAME / 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid !== 1'b0) early++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (col_n !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0 || early != 0) begin
      failures++;
      $display("FAIL reset_mid: col_n=%b code=%0d valid=%b held=%b early=%0d want 1110/0/0/0/0",
               col_n, key_code, key_valid, key_held, early);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int f = 0; f < 6; f++) begin
      logic [15:0] p = (f < 3) ? 16'h0080 : 16'h0000;
      run_frame(p, o);
      acc = model_frame(p);
      checks++;
      if (o.pulses != (acc ? 1 : 0) || o.held_end !== m_held || o.code_end !== 4'(m_code)) begin
        failures++;
        $display("FAIL key7_after_reset f%0d: pulses=%0d held=%b code=%0d want %0d/%b/%0d",
                 f, o.pulses, o.held_end, o.code_end, acc ? 1 : 0, m_held, m_code);
      end
    end
    checks++;
    if (key_code !== 4'd7) begin
      failures++;
      $display("FAIL key7_code: got %0d want 7", key_code);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit acc, prev_held;
    logic [15:0] p = '0;
    for (int f = 0; f < 40; f++) begin
      int sel = $urandom_range(0, 9);
      if (sel <= 1) p = '0;
      else if (sel == 2) begin
        int a = $urandom_range(0, 15);
        int b = (a + $urandom_range(1, 15)) % 16;
        p = '0; p[a] = 1'b1; p[b] = 1'b1;
      end else if (sel <= 5) begin
        p = '0; p[$urandom_range(0, 15)] = 1'b1;
      end
      run_frame(p, o);
      prev_held = m_held;
      acc = model_frame(p);
      checks++;
      if (o.pulses != (acc ? 1 : 0) || (acc && o.pulse_at != FRAME - 1) ||
          o.held_mid !== prev_held || o.held_end !== m_held || o.code_end !== 4'(m_code)) begin
        failures++;
        $display("FAIL random f%0d keys=%h: pulses=%0d at=%0d held=%b/%b code=%0d want %0d %b/%b code=%0d",
                 f, p, o.pulses, o.pulse_at, o.held_mid, o.held_end, o.code_end,
                 acc ? 1 : 0, prev_held, m_held, m_code);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
